// File: rtl/lock_pkg.sv
// Shared types and width helpers for the parametrised sequential combination lock.
package lock_pkg;

    // Top-level lock FSM states.
    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        FAIL    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_e;

    // Larger of two unsigned values, used to size shared counters.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n inclusive (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : lock_pkg

// File: rtl/lock_btn_edge.sv
// Button front end: registers the previous button level, flags a press on the
// rising edge from all-zero, and decodes the one-hot level to a digit index.
module lock_btn_edge #(
    parameter int unsigned BTN_W = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BTN_W-1:0] btn_i,
    output logic             press_o,
    output logic [IDX_W-1:0] digit_o,
    output logic             invalid_o
);

    logic [BTN_W-1:0] btn_q;

    // Previous-cycle button level for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_i;
        end
    end

    // A press needs the buttons to have been fully released the cycle before.
    assign press_o = (|btn_i) & ~(|btn_q);

    // One-hot decode; more than one set bit marks the digit invalid.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        digit_o   = '0;
        invalid_o = 1'b0;
        for (int i = 0; i < BTN_W; i++) begin
            if (btn_i[i]) begin
                if (seen) begin
                    invalid_o = 1'b1;
                end
                seen    = 1'b1;
                digit_o = IDX_W'(i);
            end
        end
    end

endmodule : lock_btn_edge

// File: rtl/seq_lock_param.sv
// Parametrised sequential combination lock.
// Optional feature: define LOCK_TIMEOUT_EN to abort a partial entry after
// TIMEOUT_CYC idle cycles; the abort counts as a failed attempt.
module seq_lock_param
    import lock_pkg::*;
#(
    parameter int unsigned                          BTN_W       = 2,
    parameter int unsigned                          CODE_LEN    = 4,
    parameter logic [CODE_LEN*$clog2(BTN_W)-1:0]    CODE        = 4'b0110,
    parameter int unsigned                          OPEN_CYC    = 8,
    parameter int unsigned                          MAX_TRIES   = 3,
    parameter int unsigned                          LOCKOUT_CYC = 16,
    parameter int unsigned                          TIMEOUT_CYC = 20
) (
    input  logic                             mClk,
    input  logic                             Reset,
    input  logic [BTN_W-1:0]                 btn,
    output logic                             correct,
    output logic                             incorrect,
    output logic                             locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt
);

    localparam int unsigned IDX_W  = $clog2(BTN_W);
    localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W = cnt_width(MAX_TRIES);
    // One duration counter serves OPEN, LOCKOUT and (optionally) the ENTRY timeout.
    localparam int unsigned DUR_W  =
        cnt_width(max_u(max_u(OPEN_CYC, LOCKOUT_CYC), TIMEOUT_CYC));

    lock_state_e        state_q;
    logic [CNT_W-1:0]   idx_q;
    logic [FAIL_W-1:0]  fail_q;
    logic [DUR_W-1:0]   dur_q;
    logic               mismatch_q;
    logic               correct_q;
    logic               incorrect_q;
    logic               locked_out_q;

    logic               press;
    logic [IDX_W-1:0]   digit;
    logic               invalid;
    logic [IDX_W-1:0]   code_digit;
    logic               mismatch_all;
    logic               last_digit;
    logic [FAIL_W-1:0]  fail_inc;

    lock_btn_edge #(
        .BTN_W (BTN_W),
        .IDX_W (IDX_W)
    ) u_btn_edge (
        .clk_i     (mClk),
        .rst_i     (Reset),
        .btn_i     (btn),
        .press_o   (press),
        .digit_o   (digit),
        .invalid_o (invalid)
    );

    // Expected digit, running mismatch including the current press, saturating fail count.
    always_comb begin
        code_digit   = CODE[int'(idx_q)*IDX_W +: IDX_W];
        mismatch_all = mismatch_q | invalid | (digit != code_digit);
        last_digit   = (idx_q == CNT_W'(CODE_LEN - 1));
        fail_inc     = (fail_q == FAIL_W'(MAX_TRIES)) ? fail_q : fail_q + FAIL_W'(1);
    end

    // Lock FSM with its counters and registered outputs.
    always_ff @(posedge mClk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ENTRY;
            idx_q        <= '0;
            fail_q       <= '0;
            dur_q        <= '0;
            mismatch_q   <= 1'b0;
            correct_q    <= 1'b0;
            incorrect_q  <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                ENTRY: begin
                    if (press) begin
                        dur_q <= '0;
                        if (last_digit) begin
                            idx_q      <= '0;
                            mismatch_q <= 1'b0;
                            if (!mismatch_all) begin
                                state_q   <= OPEN;
                                correct_q <= 1'b1;
                                fail_q    <= '0;
                            end else begin
                                state_q     <= FAIL;
                                incorrect_q <= 1'b1;
                                fail_q      <= fail_inc;
                            end
                        end else begin
                            idx_q      <= idx_q + CNT_W'(1);
                            mismatch_q <= mismatch_all;
                        end
                    end
`ifdef LOCK_TIMEOUT_EN
                    else if (idx_q == '0) begin
                        dur_q <= '0;
                    end else if (dur_q == DUR_W'(TIMEOUT_CYC - 1)) begin
                        // Idle too long mid-entry: abort as a failed attempt.
                        state_q     <= FAIL;
                        incorrect_q <= 1'b1;
                        fail_q      <= fail_inc;
                        idx_q       <= '0;
                        mismatch_q  <= 1'b0;
                        dur_q       <= '0;
                    end else begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
`endif
                end
                OPEN: begin
                    if (dur_q == DUR_W'(OPEN_CYC - 1)) begin
                        state_q   <= ENTRY;
                        correct_q <= 1'b0;
                        dur_q     <= '0;
                    end else begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                FAIL: begin
                    incorrect_q <= 1'b0;
                    dur_q       <= '0;
                    if (fail_q == FAIL_W'(MAX_TRIES)) begin
                        state_q      <= LOCKOUT;
                        locked_out_q <= 1'b1;
                    end else begin
                        state_q <= ENTRY;
                    end
                end
                LOCKOUT: begin
                    if (dur_q == DUR_W'(LOCKOUT_CYC - 1)) begin
                        state_q      <= ENTRY;
                        locked_out_q <= 1'b0;
                        fail_q       <= '0;
                        dur_q        <= '0;
                    end else begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                default: begin
                    state_q <= ENTRY;
                end
            endcase
        end
    end

    assign correct    = correct_q;
    assign incorrect  = incorrect_q;
    assign locked_out = locked_out_q;
    assign digit_cnt  = (state_q == ENTRY) ? idx_q : '0;

endmodule : seq_lock_param

// File: tb/tb_seq_lock_param.sv
// Directed bench for seq_lock_param (BTN_W=2, CODE_LEN=4, code digits 0,1,1,0).
module tb_seq_lock_param;

    logic       mClk;
    logic       Reset;
    logic [1:0] btn;
    logic       correct;
    logic       incorrect;
    logic       locked_out;
    logic [2:0] digit_cnt;

    int n_checks;
    int n_fail;
    int cor_n;
    int inc_n;
    int lck_n;

    seq_lock_param dut (
        .mClk       (mClk),
        .Reset      (Reset),
        .btn        (btn),
        .correct    (correct),
        .incorrect  (incorrect),
        .locked_out (locked_out),
        .digit_cnt  (digit_cnt)
    );

    initial mClk = 1'b0;
    always #5 mClk = ~mClk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally the outputs seen in that cycle.
    task automatic tick();
        @(negedge mClk);
        if (correct)    cor_n++;
        if (incorrect)  inc_n++;
        if (locked_out) lck_n++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cor_n = 0;
        inc_n = 0;
        lck_n = 0;
    endtask

    // One-cycle press followed by release; returns just after the sampling edge.
    task automatic press(input logic [1:0] b);
        tick();
        btn = b;
        tick();
        btn = 2'b00;
    endtask

    task automatic enter4(input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic [1:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_counts();
        btn   = 2'b00;
        Reset = 1'b1;
        ticks(2);
        check_eq("rst_correct", int'(correct), 0);
        check_eq("rst_incorrect", int'(incorrect), 0);
        check_eq("rst_locked", int'(locked_out), 0);
        check_eq("rst_dcnt", int'(digit_cnt), 0);
        Reset = 1'b0;
        ticks(2);

        // Correct entry opens for exactly 8 cycles.
        clear_counts();
        press(2'b01);
        check_eq("ok_dcnt1", int'(digit_cnt), 1);
        press(2'b10);
        check_eq("ok_dcnt2", int'(digit_cnt), 2);
        press(2'b10);
        check_eq("ok_dcnt3", int'(digit_cnt), 3);
        press(2'b01);
        check_eq("ok_open_now", int'(correct), 1);
        check_eq("ok_dcnt_open", int'(digit_cnt), 0);
        ticks(12);
        check_eq("ok_open_len", cor_n, 8);
        check_eq("ok_no_incorrect", inc_n, 0);

        // Wrong entry: one-cycle incorrect pulse, then a correct entry opens.
        clear_counts();
        enter4(2'b10, 2'b10, 2'b10, 2'b01);
        check_eq("bad_pulse", int'(incorrect), 1);
        check_eq("bad_dcnt", int'(digit_cnt), 0);
        tick();
        check_eq("bad_pulse_end", int'(incorrect), 0);
        check_eq("bad_pulse_len", inc_n, 1);
        enter4(2'b01, 2'b10, 2'b10, 2'b01);
        check_eq("bad_then_open", int'(correct), 1);
        ticks(10);

        // Holding or sliding between buttons gives no extra press.
        tick();
        btn = 2'b01;
        ticks(3);
        btn = 2'b10;
        ticks(2);
        btn = 2'b00;
        tick();
        check_eq("hold_one_press", int'(digit_cnt), 1);
        press(2'b10);
        press(2'b10);
        press(2'b01);
        check_eq("hold_then_open", int'(correct), 1);
        ticks(10);

        // Three failures lock out for 16 cycles; a correct code meanwhile is ignored.
        clear_counts();
        enter4(2'b10, 2'b10, 2'b10, 2'b10);
        ticks(1);
        enter4(2'b01, 2'b01, 2'b01, 2'b01);
        ticks(1);
        enter4(2'b10, 2'b01, 2'b10, 2'b01);
        check_eq("lk_not_yet", int'(locked_out), 0);
        tick();
        check_eq("lk_start", int'(locked_out), 1);
        enter4(2'b01, 2'b10, 2'b10, 2'b01);
        check_eq("lk_ignore_open", int'(correct), 0);
        check_eq("lk_dcnt", int'(digit_cnt), 0);
        ticks(20);
        check_eq("lk_len", lck_n, 16);
        check_eq("lk_fail_pulses", inc_n, 3);
        check_eq("lk_no_open", cor_n, 0);
        enter4(2'b01, 2'b10, 2'b10, 2'b01);
        check_eq("lk_after_open", int'(correct), 1);
        ticks(10);

        // Two buttons at once is an invalid digit but still counts as a press.
        clear_counts();
        press(2'b01);
        press(2'b11);
        check_eq("inv_dcnt", int'(digit_cnt), 2);
        press(2'b10);
        press(2'b01);
        check_eq("inv_fail", int'(incorrect), 1);
        check_eq("inv_no_open", int'(correct), 0);
        ticks(2);

        // Reset mid-entry aborts to idle.
        press(2'b01);
        press(2'b10);
        check_eq("rmid_dcnt", int'(digit_cnt), 2);
        Reset = 1'b1;
        #1;
        check_eq("rmid_dcnt0", int'(digit_cnt), 0);
        tick();
        Reset = 1'b0;
        enter4(2'b01, 2'b10, 2'b10, 2'b01);
        check_eq("rmid_open", int'(correct), 1);
        ticks(10);

        // Reset during lockout clears it at once.
        enter4(2'b10, 2'b10, 2'b10, 2'b10);
        ticks(1);
        enter4(2'b10, 2'b10, 2'b10, 2'b10);
        ticks(1);
        enter4(2'b10, 2'b10, 2'b10, 2'b10);
        ticks(3);
        check_eq("rlk_locked", int'(locked_out), 1);
        Reset = 1'b1;
        #1;
        check_eq("rlk_cleared", int'(locked_out), 0);
        check_eq("rlk_incorrect", int'(incorrect), 0);
        tick();
        Reset = 1'b0;
        enter4(2'b01, 2'b10, 2'b10, 2'b01);
        check_eq("rlk_open", int'(correct), 1);
        ticks(10);

        // Idle after a partial entry.
        clear_counts();
        press(2'b01);
        ticks(25);
`ifdef LOCK_TIMEOUT_EN
        check_eq("tmo_pulse", inc_n, 1);
        check_eq("tmo_dcnt", int'(digit_cnt), 0);
        enter4(2'b01, 2'b10, 2'b10, 2'b01);
        check_eq("tmo_open", int'(correct), 1);
`else
        check_eq("tmo_none", inc_n, 0);
        check_eq("tmo_dcnt", int'(digit_cnt), 1);
        press(2'b10);
        press(2'b10);
        press(2'b01);
        check_eq("tmo_open", int'(correct), 1);
`endif
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_lock_param
